// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths, the prefetch entry type and a PC alignment
// helper used by the instruction fetch unit and its prefetch FIFO.
//   ADDR_W        : fetch address width
//   INSTR_W       : instruction word width
//   fetch_entry_t : one prefetched instruction tagged with its address
package ifetch_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Force a target address onto a word boundary.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fetch_fifo.sv
// fetch_fifo: circular prefetch buffer of fetch_entry_t.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   push_i, wdata_i   : write wdata_i at the tail
//   pop_i             : retire the head entry
//   flush_i           : drop every entry (wins over push/pop)
//   head_o            : entry at the head (meaningless when empty_o=1)
//   count_o           : number of valid entries
//   full_o, empty_o   : occupancy flags
// Storage is not reset; only the pointers and count are, which is
// enough to invalidate anything left in the array.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           wdata_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  fetch_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_FULL);
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

  // Guard against overflow/underflow even if the caller misbehaves;
  // a push into a full buffer is legal only alongside a pop.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PTR_W'(1);
      if (do_pop)  head_d = head_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= wdata_i;
  end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: sequential instruction fetcher with a small prefetch buffer.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   imem_pc            : fetch address to instruction memory (== fpc)
//   imem_instr         : instruction for imem_pc, same cycle
//   instr_valid        : buffer head is valid
//   instr, instr_pc    : head instruction and its address (0 when empty)
//   instr_ready        : consumer takes the head this cycle
//   redirect           : flush and restart fetch at redirect_pc
//   redirect_pc        : new fetch target (low two bits ignored)
//   fetch_count        : pop counter, present only with IFETCH_PERF_EN
// Optional build macro: IFETCH_PERF_EN adds the fetch_count output.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        fetch_count
`endif
);

  logic [ADDR_W-1:0]      fpc_q, fpc_d;
  logic                   push, pop;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  fetch_entry_t           head, wentry;

  // Redirect overrides both push and pop; a pop frees a slot for a
  // same-cycle push so a full buffer still streams at one per cycle.
  assign pop  = !fifo_empty && instr_ready && !redirect;
  assign push = !redirect && (!fifo_full || pop);

  assign wentry.pc    = fpc_q;
  assign wentry.instr = imem_instr;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i (wentry),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    fpc_d = fpc_q;
    if (redirect)  fpc_d = align_pc(redirect_pc);
    else if (push) fpc_d = fpc_q + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fpc_q <= RESET_PC;
    else       fpc_q <= fpc_d;
  end

  assign imem_pc     = fpc_q;
  assign instr_valid = (fifo_count != '0);
  assign instr       = fifo_empty ? '0 : head.instr;
  assign instr_pc    = fifo_empty ? '0 : head.pc;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    fetch_count_q <= '0;
    else if (pop) fetch_count_q <= fetch_count_q + 32'd1;
  end

  assign fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit. A queue-based reference model of
// the prefetch buffer tracks the fetch pointer and pending addresses.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count;
`endif

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  assign imem_instr = mem[imem_pc[9:2]];

  ifetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_pc     (imem_pc),
    .imem_instr  (imem_instr),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: fetch pointer, queue of pending addresses, pop count.
  logic [31:0] m_fpc;
  logic [31:0] m_q [$];
  int unsigned m_pops;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return mem[pc[9:2]];
  endfunction

  task automatic model_reset();
    m_fpc = RESET_PC;
    m_q.delete();
    m_pops = 0;
  endtask

  // Advance the model by one clock using the inputs as currently driven,
  // then let the DUT take the same edge and settle.
  task automatic tick();
    bit do_pop, do_push;
    if (redirect) begin
      m_q.delete();
      m_fpc = {redirect_pc[31:2], 2'b00};
    end else begin
      do_pop  = (m_q.size() != 0) && instr_ready;
      do_push = (m_q.size() < DEPTH) || do_pop;
      if (do_pop) begin
        void'(m_q.pop_front());
        m_pops++;
      end
      if (do_push) begin
        m_q.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset       = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || imem_pc !== RESET_PC) begin
      failures++;
      $display("FAIL reset_state valid=%b instr=%h pc=%h imem_pc=%h, want 0/0/0/%h",
               instr_valid, instr, instr_pc, imem_pc, RESET_PC);
    end
`ifdef IFETCH_PERF_EN
    checks++;
    if (fetch_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_fetch_count got=%0d want=0", fetch_count);
    end
`endif
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_stream();
    release_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4) || instr !== mem[i]) begin
        failures++;
        $display("FAIL stream[%0d] valid=%b pc=%h instr=%h, want 1/%h/%h",
                 i, instr_valid, instr_pc, instr, 32'(i * 4), mem[i]);
      end
    end
  endtask

  task automatic test_stall();
    release_reset();
    instr_ready = 1'b0;
    repeat (5) tick();
    checks++;
    if (instr_valid !== 1'b1 || imem_pc !== 32'h8 || instr_pc !== 32'h0 || instr !== mem[0]) begin
      failures++;
      $display("FAIL stall_hold valid=%b imem_pc=%h pc=%h instr=%h, want 1/8/0/%h",
               instr_valid, imem_pc, instr_pc, instr, mem[0]);
    end
    instr_ready = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(i * 4) || instr !== mem[i]) begin
        failures++;
        $display("FAIL stall_drain[%0d] valid=%b pc=%h instr=%h, want 1/%h/%h",
                 i, instr_valid, instr_pc, instr, 32'(i * 4), mem[i]);
      end
    end
  endtask

  task automatic test_redirect();
    release_reset();
    instr_ready = 1'b0;
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_pc !== 32'h100 || instr_pc !== 32'h0 || instr !== 32'h0) begin
      failures++;
      $display("FAIL redirect_flush valid=%b imem_pc=%h pc=%h instr=%h, want 0/100/0/0",
               instr_valid, imem_pc, instr_pc, instr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem[8'h40]) begin
      failures++;
      $display("FAIL redirect_refetch valid=%b pc=%h instr=%h, want 1/100/%h",
               instr_valid, instr_pc, instr, mem[8'h40]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wexp [3];
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== wexp[i] || instr !== word_at(wexp[i])) begin
        failures++;
        $display("FAIL wrap[%0d] valid=%b pc=%h instr=%h, want 1/%h/%h",
                 i, instr_valid, instr_pc, instr, wexp[i], word_at(wexp[i]));
      end
    end
  endtask

  task automatic test_async_reset();
    release_reset();
    instr_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (instr_valid !== 1'b1 || imem_pc !== 32'h8) begin
      failures++;
      $display("FAIL async_pre valid=%b imem_pc=%h, want 1/8", instr_valid, imem_pc);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || imem_pc !== RESET_PC || instr_pc !== 32'h0 || instr !== 32'h0) begin
      failures++;
      $display("FAIL async_reset valid=%b imem_pc=%h pc=%h instr=%h, want 0/%h/0/0",
               instr_valid, imem_pc, instr_pc, instr, RESET_PC);
    end
    #2;
    reset = 1'b0;
    model_reset();
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== RESET_PC || instr !== word_at(RESET_PC)) begin
      failures++;
      $display("FAIL async_restart valid=%b pc=%h instr=%h, want 1/%h/%h",
               instr_valid, instr_pc, instr, RESET_PC, word_at(RESET_PC));
    end
  endtask

  task automatic test_random();
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
    release_reset();
    for (int c = 0; c < 400; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      tick();
      e_valid = (m_q.size() != 0);
      e_pc    = e_valid ? m_q[0] : 32'h0;
      e_instr = e_valid ? word_at(m_q[0]) : 32'h0;
      checks++;
      if (instr_valid !== e_valid || instr_pc !== e_pc || instr !== e_instr || imem_pc !== m_fpc) begin
        failures++;
        $display("FAIL random[%0d] valid=%b/%b pc=%h/%h instr=%h/%h imem_pc=%h/%h (got/want)",
                 c, instr_valid, e_valid, instr_pc, e_pc, instr, e_instr, imem_pc, m_fpc);
      end
    end
    redirect = 1'b0;
`ifdef IFETCH_PERF_EN
    checks++;
    if (fetch_count !== 32'(m_pops)) begin
      failures++;
      $display("FAIL random_fetch_count got=%0d want=%0d", fetch_count, m_pops);
    end
`endif
  endtask

`ifdef IFETCH_PERF_EN
  task automatic test_perf();
    int cyc;
    release_reset();
    instr_ready = 1'b1;
    cyc = 0;
    while (m_pops < 5 && cyc < 50) begin
      tick();
      cyc++;
    end
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    while (m_pops < 10 && cyc < 50) begin
      tick();
      cyc++;
    end
    checks++;
    if (fetch_count !== 32'd10 || m_pops != 10) begin
      failures++;
      $display("FAIL perf_count got=%0d want=10 (model pops=%0d)", fetch_count, m_pops);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (fetch_count !== 32'd0) begin
      failures++;
      $display("FAIL perf_reset got=%0d want=0", fetch_count);
    end
    reset = 1'b0;
    model_reset();
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset       = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
`ifdef IFETCH_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, prefetch buffer entries (power of two, >= 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_pc  output  32  fetch address presented to instruction memory (word index = imem_pc[9:2]).
REQ-006 SHALL have port imem_instr  input  32  instruction returned combinationally for imem_pc in the same cycle.
REQ-007 SHALL have port instr_valid  output  1  buffer head holds a valid instruction.
REQ-008 SHALL have port instr  output  32  head instruction.
REQ-009 SHALL have port instr_pc  output  32  address of head instruction.
REQ-010 SHALL have port instr_ready  input  1  consumer accepts head this cycle.
REQ-011 SHALL have port redirect  input  1  branch/jump: flush and refetch.
REQ-012 SHALL have port redirect_pc  input  32  new fetch address when redirect=1.

Function
REQ-013 SHALL hold fetch pointer fpc; imem_pc SHALL equal fpc combinationally.
REQ-014 SHALL push {fpc, imem_instr} into the buffer tail and advance fpc by 4 on a clock edge when redirect=0 and (count<DEPTH or a pop occurs that edge).
REQ-015 SHALL pop the head when instr_valid=1 and instr_ready=1 (pop and push in one cycle allowed; count unchanged).
REQ-016 SHALL drive instr_valid = (count != 0); instr and instr_pc SHALL be 0 when count=0.
REQ-017 SHALL deliver instructions in strictly ascending-address order between redirects, none dropped or duplicated.
REQ-018 SHALL, on redirect=1, flush all entries (count<=0), load fpc<={redirect_pc[31:2],2'b00}, and perform no push; redirect has priority over push and pop.
REQ-019 SHALL wrap fpc from 32'hFFFF_FFFC to 32'h0000_0000 (modulo 2^32).
REQ-020 SHALL stall fetch (fpc, buffer unchanged) when full and instr_ready=0.
REQ-021 SHALL present first valid instruction one cycle after the first clock edge following reset deassertion (single-cycle fetch latency).
REQ-022 SHALL keep instr/instr_pc stable while instr_valid=1 and instr_ready=0.

Reset
REQ-023 SHALL, on reset assertion, immediately set fpc=RESET_PC, count=0, head/tail pointers=0, instr_valid=0, instr=0, instr_pc=0, independent of clk.
REQ-024 SHALL discard any buffered entries on reset mid-operation; buffer contents need not be cleared, only invalidated.

Configuration
REQ-025 SHALL, with macro IFETCH_PERF_EN defined, add output fetch_count (32 bits) counting pops, reset to 0, wrapping at 2^32, unaffected by redirect.
REQ-026 SHALL, without IFETCH_PERF_EN, have no fetch_count port and no counter logic.

Structure
REQ-027 SHALL place ADDR_W=32, INSTR_W=32, and typedef fetch_entry_t {pc, instr} in package ifetch_pkg.
REQ-028 SHALL implement the buffer as sub-module fetch_fifo (DEPTH entries of fetch_entry_t, push/pop/flush, count output).

Verification
REQ-029 Reset release, RESET_PC=0, instr_ready=1, imem returns addr-tagged words -> instr_pc 0,4,8,... one per cycle from cycle 1, instr matches.
REQ-030 instr_ready=0 for 5 cycles after reset -> count reaches 2, imem_pc holds 32'h8, instr_pc stays 0; ready=1 -> 0,4,8 delivered back-to-back.
REQ-031 redirect=1, redirect_pc=32'h0000_0103 while full -> next cycle instr_valid=0, imem_pc=32'h100; following cycle instr_pc=32'h100.
REQ-032 redirect_pc=32'hFFFF_FFF8, ready=1 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-033 reset asserted between clock edges while count=2 -> instr_valid=0 and imem_pc=RESET_PC immediately, before next posedge.
REQ-034 IFETCH_PERF_EN defined, 10 pops with one redirect in between -> fetch_count=10; reset -> 0.
